// File: rtl/wb_stage_if.sv
// wb_stage_if: mem->wb lane-pair bus and the wb forwarding bus
interface wb_stage_if;
  logic        flush, mem_valid, wb_allowin;
  logic        mem_a_valid, mem_b_valid;
  logic [31:0] mem_a_pc, mem_b_pc;
  logic        mem_a_have_exception, mem_b_have_exception;
  logic [4:0]  mem_a_dest, mem_b_dest;
  logic [31:0] mem_a_result, mem_b_result;
  logic        wb_a_valid, wb_a_forwardable, wb_b_valid, wb_b_forwardable;
  logic [4:0]  wb_a_dest, wb_b_dest;
  logic [31:0] wb_a_result, wb_b_result;
  modport master (
    output flush, mem_valid, mem_a_valid, mem_b_valid, mem_a_pc, mem_b_pc,
           mem_a_have_exception, mem_b_have_exception, mem_a_dest, mem_b_dest,
           mem_a_result, mem_b_result,
    input  wb_allowin, wb_a_valid, wb_a_forwardable, wb_a_dest, wb_a_result,
           wb_b_valid, wb_b_forwardable, wb_b_dest, wb_b_result
  );
  modport slave (
    input  flush, mem_valid, mem_a_valid, mem_b_valid, mem_a_pc, mem_b_pc,
           mem_a_have_exception, mem_b_have_exception, mem_a_dest, mem_b_dest,
           mem_a_result, mem_b_result,
    output wb_allowin, wb_a_valid, wb_a_forwardable, wb_a_dest, wb_a_result,
           wb_b_valid, wb_b_forwardable, wb_b_dest, wb_b_result
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: dual-lane writeback, 32x32 regfile with 4 read ports; WB_COMMIT_TRACE_EN adds debug_wb_* trace ports
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  wb_stage_if.slave   bus,
  input  logic [4:0]  r1_addr,
  input  logic [4:0]  r2_addr,
  input  logic [4:0]  r3_addr,
  input  logic [4:0]  r4_addr,
  output logic [31:0] r1_data,
  output logic [31:0] r2_data,
  output logic [31:0] r3_data,
  output logic [31:0] r4_data,
  output logic [63:0] commit_count
`ifdef WB_COMMIT_TRACE_EN
  ,
  output logic [31:0] debug_wb_a_pc,
  output logic        debug_wb_a_rf_we,
  output logic [4:0]  debug_wb_a_rf_wnum,
  output logic [31:0] debug_wb_a_rf_wdata,
  output logic [31:0] debug_wb_b_pc,
  output logic        debug_wb_b_rf_we,
  output logic [4:0]  debug_wb_b_rf_wnum,
  output logic [31:0] debug_wb_b_rf_wdata
`endif
);
  logic        a_valid, b_valid, a_exc, b_exc, we_a, we_b;
  logic [4:0]  a_dest, b_dest;
  logic [31:0] a_result, b_result;
  logic [31:0] rf [32];
  always_comb begin
    we_a = a_valid && !a_exc && a_dest != 5'd0;
    we_b = b_valid && !b_exc && b_dest != 5'd0;
  end
  assign bus.wb_allowin       = reset;
  assign bus.wb_a_valid       = a_valid;
  assign bus.wb_a_forwardable = we_a;
  assign bus.wb_a_dest        = a_dest;
  assign bus.wb_a_result      = a_result;
  assign bus.wb_b_valid       = b_valid;
  assign bus.wb_b_forwardable = we_b;
  assign bus.wb_b_dest        = b_dest;
  assign bus.wb_b_result      = b_result;
  assign r1_data = r1_addr == 5'd0 ? '0 : rf[r1_addr];
  assign r2_data = r2_addr == 5'd0 ? '0 : rf[r2_addr];
  assign r3_data = r3_addr == 5'd0 ? '0 : rf[r3_addr];
  assign r4_data = r4_addr == 5'd0 ? '0 : rf[r4_addr];
  // lane b's write is issued last so it wins on an equal dest
  always_ff @(posedge clk) begin
    if (!reset) begin
      {a_valid, b_valid, a_exc, b_exc, a_dest, b_dest, a_result, b_result} <= '0;
      commit_count <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      a_valid      <= bus.mem_valid && bus.mem_a_valid && !bus.flush;
      b_valid      <= bus.mem_valid && bus.mem_b_valid && !bus.flush;
      a_exc        <= bus.mem_a_have_exception;
      b_exc        <= bus.mem_b_have_exception;
      a_dest       <= bus.mem_a_dest;
      b_dest       <= bus.mem_b_dest;
      a_result     <= bus.mem_a_result;
      b_result     <= bus.mem_b_result;
      commit_count <= commit_count + 64'(a_valid) + 64'(b_valid);
      if (we_a) rf[a_dest] <= a_result;
      if (we_b) rf[b_dest] <= b_result;
    end
  end
`ifdef WB_COMMIT_TRACE_EN
  logic [31:0] a_pc, b_pc;
  always_ff @(posedge clk) begin
    if (!reset) {a_pc, b_pc} <= '0;
    else begin
      a_pc <= bus.mem_a_pc;
      b_pc <= bus.mem_b_pc;
    end
  end
  assign debug_wb_a_pc       = a_pc;
  assign debug_wb_a_rf_we    = we_a;
  assign debug_wb_a_rf_wnum  = a_dest;
  assign debug_wb_a_rf_wdata = a_result;
  assign debug_wb_b_pc       = b_pc;
  assign debug_wb_b_rf_we    = we_b;
  assign debug_wb_b_rf_wnum  = b_dest;
  assign debug_wb_b_rf_wdata = b_result;
`endif
endmodule
